// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode values and fetch FSM states.
// HALT_DETECT_EN adds the S_HALT fetch state.
package cpu_pkg;

    localparam int OPCODE_W    = 3;
    localparam int INSTR_W     = 8;
    localparam int OPERAND_W   = INSTR_W - OPCODE_W;
    localparam int OPCODE_MSB  = INSTR_W - 1;
    localparam int OPCODE_LSB  = INSTR_W - OPCODE_W;
    localparam int OPERAND_MSB = OPCODE_LSB - 1;

    localparam logic [OPCODE_W-1:0] OP_NOP = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_LD  = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
`ifdef HALT_DETECT_EN
        ,
        S_HALT  = 2'd3
`endif
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: jump load has priority over increment; increment wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int          ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next PC selection
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ONE;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC storage
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches over a req/valid handshake, splits opcode/operand, pulses En, then advances PC.
// HALT_DETECT_EN stops fetching on an OP_HLT instruction until Reset.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = INSTR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Run,
    output logic                  Imem_req,
    output logic [ADDR_W-1:0]     Imem_addr,
    input  logic                  Imem_valid,
    input  logic [DATA_W-1:0]     Imem_data,
    output logic [OPCODE_W-1:0]   Opcode,
    output logic [DATA_W-4:0]     Operand,
    output logic                  En,
    input  logic                  Exec_done,
    input  logic                  Jump_en,
    input  logic [ADDR_W-1:0]     Jump_addr,
    output logic [ADDR_W-1:0]     PC,
    output logic                  Halted
);

    fetch_state_e          state_d, state_q;
    logic                  imem_req_d, imem_req_q;
    logic                  en_d, en_q;
    logic [OPCODE_W-1:0]   opcode_d, opcode_q;
    logic [DATA_W-4:0]     operand_d, operand_q;
    logic                  pc_load_s;
    logic                  pc_inc_s;
    logic [ADDR_W-1:0]     pc_s;
    logic [OPCODE_W-1:0]   fetched_opcode_s;

    assign fetched_opcode_s = Imem_data[DATA_W-1 -: OPCODE_W];

`ifdef HALT_DETECT_EN
    logic halted_d, halted_q;
`endif

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (Clk),
        .reset     (Reset),
        .load      (pc_load_s),
        .inc       (pc_inc_s),
        .load_addr (Jump_addr),
        .pc        (pc_s)
    );

    // Fetch FSM next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        imem_req_d = imem_req_q;
        en_d       = 1'b0;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        pc_load_s  = 1'b0;
        pc_inc_s   = 1'b0;
`ifdef HALT_DETECT_EN
        halted_d   = halted_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_req_q) begin
                    if (Imem_valid) begin
                        opcode_d   = fetched_opcode_s;
                        operand_d  = Imem_data[DATA_W-4:0];
                        imem_req_d = 1'b0;
`ifdef HALT_DETECT_EN
                        if (fetched_opcode_s == OP_HLT) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                            en_d    = 1'b1;
                        end
`else
                        state_d = S_ISSUE;
                        en_d    = 1'b1;
`endif
                    end else begin
                        imem_req_d = 1'b1;
                    end
                end else begin
                    imem_req_d = Run;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Exec_done) begin
                    // Request the next word on the same edge the PC moves, giving a 3-cycle minimum period
                    state_d    = S_FETCH;
                    imem_req_d = Run;
                    if (Jump_en) begin
                        pc_load_s = 1'b1;
                    end else begin
                        pc_inc_s = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
`ifdef HALT_DETECT_EN
            S_HALT: begin
                imem_req_d = 1'b0;
                halted_d   = 1'b1;
            end
`endif
            default: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Fetch FSM state and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b0;
            en_q       <= 1'b0;
            opcode_q   <= {OPCODE_W{1'b0}};
            operand_q  <= {(DATA_W-3){1'b0}};
`ifdef HALT_DETECT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            en_q       <= en_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
`ifdef HALT_DETECT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign Imem_req  = imem_req_q;
    assign Imem_addr = pc_s;
    assign PC        = pc_s;
    assign En        = en_q;
    assign Opcode    = opcode_q;
    assign Operand   = operand_q;
`ifdef HALT_DETECT_EN
    assign Halted    = halted_q;
`else
    assign Halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch/execute transactions plus reset, Run and halt sequences.
module tb_instr_fetch_unit;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Imem_req;
    logic [4:0] Imem_addr;
    logic       Imem_valid;
    logic [7:0] Imem_data;
    logic [2:0] Opcode;
    logic [4:0] Operand;
    logic       En;
    logic       Exec_done;
    logic       Jump_en;
    logic [4:0] Jump_addr;
    logic [4:0] PC;
    logic       Halted;

    int checks;
    int failures;

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(8), .RESET_PC(0)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Imem_req   (Imem_req),
        .Imem_addr  (Imem_addr),
        .Imem_valid (Imem_valid),
        .Imem_data  (Imem_data),
        .Opcode     (Opcode),
        .Operand    (Operand),
        .En         (En),
        .Exec_done  (Exec_done),
        .Jump_en    (Jump_en),
        .Jump_addr  (Jump_addr),
        .PC         (PC),
        .Halted     (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         xdelay;
        logic       jmp;
        logic [4:0] jaddr;
        logic [2:0] exp_opc;
        logic [4:0] exp_opr;
        logic [4:0] exp_pc;
    } vec_t;

    vec_t vecs[8];
    logic [4:0] cur_pc;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (Imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", {31'd0, Imem_req}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_req();
        chk($sformatf("v%0d_addr", idx), {27'd0, Imem_addr}, {27'd0, cur_pc});
        for (int i = 0; i < v.lat; i++) begin
            tick();
            chk($sformatf("v%0d_req_hold", idx), {31'd0, Imem_req}, 32'd1);
            chk($sformatf("v%0d_addr_hold", idx), {27'd0, Imem_addr}, {27'd0, cur_pc});
        end
        Imem_valid = 1'b1;
        Imem_data  = v.data;
        tick();
        Imem_valid = 1'b0;
        chk($sformatf("v%0d_en", idx), {31'd0, En}, 32'd1);
        chk($sformatf("v%0d_opc", idx), {29'd0, Opcode}, {29'd0, v.exp_opc});
        chk($sformatf("v%0d_opr", idx), {27'd0, Operand}, {27'd0, v.exp_opr});
        chk($sformatf("v%0d_req_drop", idx), {31'd0, Imem_req}, 32'd0);
        tick();
        chk($sformatf("v%0d_en_low", idx), {31'd0, En}, 32'd0);
        // Jump_en without Exec_done must not move the PC
        for (int i = 0; i < v.xdelay; i++) begin
            Jump_en   = 1'b1;
            Jump_addr = 5'd7;
            tick();
            chk($sformatf("v%0d_pc_wait", idx), {27'd0, PC}, {27'd0, cur_pc});
            chk($sformatf("v%0d_en_wait", idx), {31'd0, En}, 32'd0);
        end
        Exec_done = 1'b1;
        Jump_en   = v.jmp;
        Jump_addr = v.jaddr;
        tick();
        Exec_done = 1'b0;
        Jump_en   = 1'b0;
        chk($sformatf("v%0d_pc", idx), {27'd0, PC}, {27'd0, v.exp_pc});
        chk($sformatf("v%0d_req_next", idx), {31'd0, Imem_req}, 32'd1);
        cur_pc = v.exp_pc;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        Reset      = 1'b1;
        Run        = 1'b0;
        Imem_valid = 1'b0;
        Imem_data  = 8'h00;
        Exec_done  = 1'b0;
        Jump_en    = 1'b0;
        Jump_addr  = 5'd0;
        cur_pc     = 5'd0;

        //         data          lat xd jmp  jaddr  opc     opr     pc_after
        vecs[0] = '{8'b010_00101, 1, 0, 1'b0, 5'd0,  3'b010, 5'd5,  5'd1};
        vecs[1] = '{8'h21,        0, 0, 1'b0, 5'd0,  3'b001, 5'd1,  5'd2};
        vecs[2] = '{8'h42,        0, 0, 1'b0, 5'd0,  3'b010, 5'd2,  5'd3};
        vecs[3] = '{8'h63,        0, 2, 1'b1, 5'd31, 3'b011, 5'd3,  5'd31};
        vecs[4] = '{8'h9F,        0, 0, 1'b0, 5'd0,  3'b100, 5'd31, 5'd0};
        vecs[5] = '{8'hA4,        0, 0, 1'b1, 5'd12, 3'b101, 5'd4,  5'd12};
        vecs[6] = '{8'hC7,        0, 0, 1'b1, 5'd12, 3'b110, 5'd7,  5'd12};
        vecs[7] = '{8'h1F,        3, 1, 1'b1, 5'd4,  3'b000, 5'd31, 5'd4};

        tick();
        tick();
        chk("rst_pc", {27'd0, PC}, 32'd0);
        chk("rst_req", {31'd0, Imem_req}, 32'd0);
        chk("rst_en", {31'd0, En}, 32'd0);
        chk("rst_opc", {29'd0, Opcode}, 32'd0);
        chk("rst_opr", {27'd0, Operand}, 32'd0);
        chk("rst_halt", {31'd0, Halted}, 32'd0);
        Reset = 1'b0;
        tick();
        chk("idle_req", {31'd0, Imem_req}, 32'd0);
        chk("idle_pc", {27'd0, PC}, 32'd0);
        Run = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Run dropped mid-request at PC=4
        Run = 1'b0;
        tick();
        chk("run0_req_hold1", {31'd0, Imem_req}, 32'd1);
        chk("run0_addr", {27'd0, Imem_addr}, 32'd4);
        tick();
        chk("run0_req_hold2", {31'd0, Imem_req}, 32'd1);
        Imem_valid = 1'b1;
        Imem_data  = 8'h45;
        tick();
        Imem_valid = 1'b0;
        chk("run0_en", {31'd0, En}, 32'd1);
        chk("run0_opc", {29'd0, Opcode}, 32'd2);
        chk("run0_opr", {27'd0, Operand}, 32'd5);
        tick();
        Exec_done = 1'b1;
        tick();
        Exec_done = 1'b0;
        chk("run0_pc", {27'd0, PC}, 32'd5);
        chk("run0_req_idle", {31'd0, Imem_req}, 32'd0);
        Imem_valid = 1'b1;
        Imem_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run0_idle_req", {31'd0, Imem_req}, 32'd0);
            chk("run0_idle_opc", {29'd0, Opcode}, 32'd2);
            chk("run0_idle_pc", {27'd0, PC}, 32'd5);
        end
        Imem_valid = 1'b0;
        Run = 1'b1;
        tick();
        chk("run1_req", {31'd0, Imem_req}, 32'd1);
        chk("run1_addr", {27'd0, Imem_addr}, 32'd5);

        // Reset while waiting for execution
        Imem_valid = 1'b1;
        Imem_data  = 8'h66;
        tick();
        Imem_valid = 1'b0;
        chk("rw_en", {31'd0, En}, 32'd1);
        tick();
        Reset     = 1'b1;
        Exec_done = 1'b1;
        Jump_en   = 1'b1;
        Jump_addr = 5'd9;
        tick();
        chk("rw_pc", {27'd0, PC}, 32'd0);
        chk("rw_req", {31'd0, Imem_req}, 32'd0);
        chk("rw_en0", {31'd0, En}, 32'd0);
        chk("rw_opc", {29'd0, Opcode}, 32'd0);
        chk("rw_opr", {27'd0, Operand}, 32'd0);
        Reset     = 1'b0;
        Exec_done = 1'b0;
        Jump_en   = 1'b0;
        tick();
        chk("rr_req_up", {31'd0, Imem_req}, 32'd1);

        // Reset during a pending request with coincident valid
        Reset      = 1'b1;
        Imem_valid = 1'b1;
        Imem_data  = 8'h5A;
        tick();
        chk("rr_req", {31'd0, Imem_req}, 32'd0);
        chk("rr_en", {31'd0, En}, 32'd0);
        chk("rr_opc", {29'd0, Opcode}, 32'd0);
        chk("rr_opr", {27'd0, Operand}, 32'd0);
        chk("rr_pc", {27'd0, PC}, 32'd0);
        Reset      = 1'b0;
        Imem_valid = 1'b0;
        tick();
        chk("rr_req2", {31'd0, Imem_req}, 32'd1);
        tick();
        chk("rr_no_issue", {31'd0, En}, 32'd0);
        chk("rr_req3", {31'd0, Imem_req}, 32'd1);

        // Fetch of 8'hE0 (HLT opcode)
        Imem_valid = 1'b1;
        Imem_data  = 8'hE0;
        tick();
        Imem_valid = 1'b0;
`ifdef HALT_DETECT_EN
        chk("hlt_en", {31'd0, En}, 32'd0);
        chk("hlt_halted", {31'd0, Halted}, 32'd1);
        chk("hlt_req", {31'd0, Imem_req}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            Exec_done  = i[0];
            Imem_valid = 1'b1;
            tick();
            chk("hlt_hold_req", {31'd0, Imem_req}, 32'd0);
            chk("hlt_hold_halted", {31'd0, Halted}, 32'd1);
            chk("hlt_hold_en", {31'd0, En}, 32'd0);
            chk("hlt_hold_pc", {27'd0, PC}, 32'd0);
        end
        Exec_done  = 1'b0;
        Imem_valid = 1'b0;
`else
        chk("hlt_en", {31'd0, En}, 32'd1);
        chk("hlt_opc", {29'd0, Opcode}, 32'd7);
        chk("hlt_opr", {27'd0, Operand}, 32'd0);
        chk("hlt_halted", {31'd0, Halted}, 32'd0);
        tick();
        Exec_done = 1'b1;
        tick();
        Exec_done = 1'b0;
        chk("hlt_pc", {27'd0, PC}, 32'd1);
        chk("hlt_halted2", {31'd0, Halted}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
